// File: rtl/rdata_rsp_ctrl.sv
// Read-response controller: queues read commands and drains the read-data FIFO onto the AXI R channel.
// Optional starvation timeout with SLVERR completion is enabled by defining RDATA_TIMEOUT_EN.
module rdata_rsp_ctrl #(
    parameter int ID_W           = 4,
    parameter int CMDQ_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            rclk,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [ID_W-1:0] cmd_id,
    input  logic [7:0]      cmd_len,
    input  logic            fifo_empty,
    input  logic [63:0]     fifo_data,
    output logic            fifo_read_en,
    output logic            rvalid,
    input  logic            rready,
    output logic [63:0]     rdata,
    output logic [ID_W-1:0] rid,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            busy,
    output logic            timeout_flag
);

    localparam int PW = $clog2(CMDQ_DEPTH);
    localparam int CW = PW + 1;

`ifdef RDATA_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BURST, ERR} state_t;
`else
    typedef enum logic {IDLE, BURST} state_t;
`endif

    state_t state, state_nxt;

    logic [ID_W-1:0] q_id  [CMDQ_DEPTH];
    logic [7:0]      q_len [CMDQ_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;

    logic [ID_W-1:0] cur_id;
    logic [8:0]      fetch_left;
    logic            err_load;
    logic            hs_last;

    assign cmd_ready = (count < CW'(CMDQ_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);
    assign hs_last   = rvalid && rready && rlast;

    assign fifo_read_en = (state == BURST) && !fifo_empty && (fetch_left != '0) && (!rvalid || rready);

    always_ff @(posedge rclk) begin
        if (push) begin
            q_id[wr_ptr]  <= cmd_id;
            q_len[wr_ptr] <= cmd_len;
        end
    end

    always_ff @(posedge rclk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef RDATA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] starve_cnt;
    logic          starved;

    assign err_load = (state == ERR) && (fetch_left != '0) && (!rvalid || rready);
    assign starved  = (starve_cnt == TW'(TIMEOUT_CYCLES)) && !rvalid && !fifo_read_en;

    always_ff @(posedge rclk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt   <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (pop || fifo_read_en)
                starve_cnt <= '0;
            else if ((state == BURST) && (fetch_left != '0) && fifo_empty &&
                     (starve_cnt != TW'(TIMEOUT_CYCLES)))
                starve_cnt <= starve_cnt + TW'(1);
            if ((state == BURST) && starved)
                timeout_flag <= 1'b1;
        end
    end
`else
    assign err_load     = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge rclk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (pop) state_nxt = BURST;
            BURST: begin
                if (hs_last) state_nxt = IDLE;
`ifdef RDATA_TIMEOUT_EN
                else if (starved) state_nxt = ERR;
            end
            ERR: begin
                if (hs_last) state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Error beats reuse the same output register path as FIFO beats.
    always_ff @(posedge rclk or negedge resetn) begin
        if (!resetn) begin
            cur_id     <= '0;
            fetch_left <= '0;
            rvalid     <= 1'b0;
            rdata      <= '0;
            rid        <= '0;
            rresp      <= 2'b00;
            rlast      <= 1'b0;
        end else begin
            if (pop) begin
                cur_id     <= q_id[rd_ptr];
                fetch_left <= {1'b0, q_len[rd_ptr]} + 9'd1;
            end else if (fifo_read_en || err_load) begin
                fetch_left <= fetch_left - 9'd1;
            end

            if (fifo_read_en) begin
                rdata  <= fifo_data;
                rid    <= cur_id;
                rresp  <= 2'b00;
                rlast  <= (fetch_left == 9'd1);
                rvalid <= 1'b1;
            end else if (err_load) begin
                rdata  <= '0;
                rid    <= cur_id;
                rresp  <= 2'b10;
                rlast  <= (fetch_left == 9'd1);
                rvalid <= 1'b1;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rdata_rsp_ctrl.sv
// Bench for rdata_rsp_ctrl: FIFO model, command/beat scoreboard checked every cycle, plus directed literal checks.
module tb_rdata_rsp_ctrl;

    localparam int ID_W = 4;
`ifdef RDATA_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic            rclk;
    logic            resetn;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [ID_W-1:0] cmd_id;
    logic [7:0]      cmd_len;
    logic            fifo_empty;
    logic [63:0]     fifo_data;
    logic            fifo_read_en;
    logic            rvalid;
    logic            rready;
    logic [63:0]     rdata;
    logic [ID_W-1:0] rid;
    logic [1:0]      rresp;
    logic            rlast;
    logic            busy;
    logic            timeout_flag;

    rdata_rsp_ctrl #(.ID_W(ID_W), .CMDQ_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .rclk(rclk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp),
        .rlast(rlast), .busy(busy), .timeout_flag(timeout_flag)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // External FIFO: stimulus writes, DUT pops.
    logic [63:0] fmem [256];
    int unsigned fwr = 0;
    int unsigned frd = 0;
    assign fifo_empty = (fwr == frd);
    assign fifo_data  = fmem[frd[7:0]];

    always @(posedge rclk)
        if (resetn && fifo_read_en && !fifo_empty) frd <= frd + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    typedef struct {
        logic [ID_W-1:0] id;
        int              len;
        int              ok;
    } cmd_t;

    cmd_t        mq[$];
    int          beat = 0;
    int unsigned mrd = 0;
    int          rd_cnt = 0;
    int          ok_hs = 0;
    int          hs_total = 0;
    int          ok_lim = 256;
    logic        hold = 1'b0;
    logic [63:0] h_data;
    logic [ID_W-1:0] h_id;
    logic [1:0]  h_resp;
    logic        h_last;

    // Scoreboard: every accepted command yields len+1 beats; the first 'ok' carry FIFO words in order,
    // the rest are SLVERR with zero data.
    always @(negedge rclk) begin
        if (!resetn) begin
            mq.delete();
            beat   = 0;
            mrd    = frd;
            rd_cnt = 0;
            ok_hs  = 0;
            hold   = 1'b0;
            chk("rst_rvalid", 64'(rvalid), 64'd0);
            chk("rst_rden", 64'(fifo_read_en), 64'd0);
        end else begin
            chk("busy", 64'(busy), 64'(mq.size() > 0));
            chk("rd_ahead", 64'(rd_cnt - ok_hs),
                64'((rvalid && mq.size() > 0 && beat < mq[0].ok) ? 1 : 0));
            if (mq.size() == 0) begin
                chk("idle_rvalid", 64'(rvalid), 64'd0);
                chk("idle_rden", 64'(fifo_read_en), 64'd0);
            end
            if (hold) begin
                chk("hold_rvalid", 64'(rvalid), 64'd1);
                chk("hold_rdata", rdata, h_data);
                chk("hold_rid", 64'(rid), 64'(h_id));
                chk("hold_rresp", 64'(rresp), 64'(h_resp));
                chk("hold_rlast", 64'(rlast), 64'(h_last));
            end
            if (rvalid && !rready) chk("stall_rden", 64'(fifo_read_en), 64'd0);
            if (rvalid && rready) begin
                if (mq.size() == 0) begin
                    fail("unexpected_beat");
                end else begin
                    logic ok;
                    ok = (beat < mq[0].ok);
                    chk("rid", 64'(rid), 64'(mq[0].id));
                    chk("rresp", 64'(rresp), ok ? 64'd0 : 64'd2);
                    chk("rdata", rdata, ok ? fmem[mrd[7:0]] : 64'd0);
                    chk("rlast", 64'(rlast), 64'(beat == mq[0].len));
                    if (ok) begin
                        mrd++;
                        ok_hs++;
                    end
                    hs_total++;
                    if (beat == mq[0].len) begin
                        void'(mq.pop_front());
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
            end
            hold   = rvalid && !rready;
            h_data = rdata;
            h_id   = rid;
            h_resp = rresp;
            h_last = rlast;
            if (fifo_read_en && !fifo_empty) rd_cnt++;
            if (cmd_valid && cmd_ready) mq.push_back('{cmd_id, int'(cmd_len), ok_lim});
        end
    end

    task automatic push_word(input logic [63:0] w);
        fmem[fwr[7:0]] = w;
        fwr++;
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic send_cmd(input logic [ID_W-1:0] id, input logic [7:0] len);
        logic acc;
        int   n;
        cmd_valid = 1'b1;
        cmd_id    = id;
        cmd_len   = len;
        acc       = 1'b0;
        n         = 0;
        while (!acc && n < 100) begin
            @(negedge rclk);
            acc = cmd_ready;
            step();
            n++;
        end
        if (!acc) fail("cmd_accept");
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (n < bound && !(mq.size() == 0 && !busy)) begin
            step();
            n++;
        end
        if (n >= bound) fail("wait_idle");
    endtask

    logic [3:0] pat;
    int         hs0;
    int         n;

    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_id    = '0;
        cmd_len   = '0;
        rready    = 1'b0;
        pat       = 4'b1001;
        #2;
        chk("reset_rvalid", 64'(rvalid), 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        chk("reset_rid", 64'(rid), 64'd0);
        chk("reset_rresp", 64'(rresp), 64'd0);
        chk("reset_rlast", 64'(rlast), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_timeout", 64'(timeout_flag), 64'd0);
        step();
        resetn = 1'b1;
        step();

        // Single burst: latency and beat sequence
        rready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(64'hA000_0000_0000_0000 + 64'(i));
        send_cmd(4'd3, 8'd3);
        chk("lat_n0_rvalid", 64'(rvalid), 64'd0);
        step();
        chk("lat_n1_rvalid", 64'(rvalid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sb_rvalid", 64'(rvalid), 64'd1);
            chk("sb_rid", 64'(rid), 64'd3);
            chk("sb_rdata", rdata, 64'hA000_0000_0000_0000 + 64'(i));
            chk("sb_rlast", 64'(rlast), (i == 3) ? 64'd1 : 64'd0);
        end
        step();
        chk("sb_after_rvalid", 64'(rvalid), 64'd0);
        wait_idle(20);

        // Backpressure with rready pattern 1,0,0,1
        for (int i = 0; i < 4; i++) push_word(64'hB000_0000_0000_0000 + 64'(i));
        hs0 = hs_total;
        send_cmd(4'd3, 8'd3);
        for (int i = 0; i < 24; i++) begin
            rready = pat[i % 4];
            step();
        end
        rready = 1'b1;
        wait_idle(20);
        chk("bp_beats", 64'(hs_total - hs0), 64'd4);

        // Queue fill: first command is parked in BURST, four more fill the queue
        hs0 = hs_total;
        send_cmd(4'd1, 8'd0);
        send_cmd(4'd2, 8'd1);
        send_cmd(4'd4, 8'd0);
        send_cmd(4'd5, 8'd7);
        send_cmd(4'd6, 8'd0);
        chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b1;
        cmd_id    = 4'd7;
        cmd_len   = 8'd0;
        step();
        step();
        chk("full_still", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 13; i++) push_word(64'hC000_0000_0000_0000 + 64'(i));
        wait_idle(100);
        chk("full_beats", 64'(hs_total - hs0), 64'd13);
        chk("full_fifo_drained", 64'(fwr - frd), 64'd0);

        // Reset during beat 2 of 4
        for (int i = 0; i < 4; i++) push_word(64'hD000_0000_0000_0000 + 64'(i));
        hs0 = hs_total;
        send_cmd(4'd9, 8'd3);
        n = 0;
        while (hs_total < hs0 + 1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) fail("rst_wait_beat");
        chk("rst_pre_rvalid", 64'(rvalid), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_mid_rlast", 64'(rlast), 64'd0);
        fwr = frd;
        step();
        step();
        resetn = 1'b1;
        step();
        push_word(64'hE000_0000_0000_00EE);
        hs0 = hs_total;
        send_cmd(4'd10, 8'd0);
        wait_idle(20);
        chk("rst_after_beats", 64'(hs_total - hs0), 64'd1);

`ifdef RDATA_TIMEOUT_EN
        // Starvation: one word for a four-beat burst
        push_word(64'hF000_0000_0000_0001);
        hs0    = hs_total;
        ok_lim = 1;
        send_cmd(4'd5, 8'd3);
        ok_lim = 256;
        wait_idle(200);
        chk("to_beats", 64'(hs_total - hs0), 64'd4);
        chk("to_flag", 64'(timeout_flag), 64'd1);
        step();
        step();
        chk("to_flag_sticky", 64'(timeout_flag), 64'd1);
        resetn = 1'b0;
        #1;
        chk("to_flag_reset", 64'(timeout_flag), 64'd0);
        step();
        resetn = 1'b1;
        step();
`else
        chk("no_timeout_flag", 64'(timeout_flag), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
